// File: rtl/mii_mac_rx_checker.sv
// rtl/mii_mac_rx_checker.sv - MII receive-side frame checker (framing, FCS, header, counters)
//
// Delineates frames in a 64-bit / 8-lane MII stream on Start/Terminate control
// characters, checks preamble/SFD and the Ethernet FCS, captures the header
// and reports per-frame status together with saturating good/bad counters.
//
// Ports:
//   clk, i_rst            clock, asynchronous active-high reset
//   i_rx_valid            qualifies the current word; invalid words are ignored
//   i_mii_rx_d/_c         MII data (lane i = bits [8i+7:8i], lane 0 first) and control
//   o_frame_done          one-cycle pulse when a frame ends or is aborted
//   o_frame_good/_fcs_error/_framing_error   status, valid with o_frame_done
//   o_dest_address, o_src_address, o_len_type, o_payload_length   frame fields
//   o_frame_count, o_error_count             saturating good / bad frame counters
module mii_mac_rx_checker #(
  parameter int          PAYLOAD_MAX_SIZE = 1500,
  parameter logic [31:0] CRC_RESIDUE      = 32'hDEBB20E3
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  input  logic [63:0] i_mii_rx_d,
  input  logic [7:0]  i_mii_rx_c,
  output logic        o_frame_done,
  output logic        o_frame_good,
  output logic        o_fcs_error,
  output logic        o_framing_error,
  output logic [47:0] o_dest_address,
  output logic [47:0] o_src_address,
  output logic [15:0] o_len_type,
  output logic [15:0] o_payload_length,
  output logic [31:0] o_frame_count,
  output logic [31:0] o_error_count
);

  localparam logic [15:0] MAX_N = 16'(PAYLOAD_MAX_SIZE + 18);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t       state, state_n;
  logic [31:0]  crc, crc_n, crc_calc;
  logic [15:0]  count, count_n, n_term;
  // Header bytes 0..13; byte j lives at [111-8j -: 8] so the slices map straight to the fields.
  logic [111:0] hdr, hdr_n, hdr_calc;
  logic [7:0]   lane_mask, lane_k;
  logic         hi_ok, pre_ok, start_cand, fd_any, all_idle;
  logic         pulse, fe, fcs_err;
  logic [15:0]  len_n;
  int           term_lane;

  // Reflected CRC-32 over the lanes selected by m (always a prefix of the word).
  function automatic logic [31:0] crc_update(input logic [31:0] c_in, input logic [63:0] d,
                                             input logic [7:0] m);
    logic [31:0] c;
    c = c_in;
    for (int l = 0; l < 8; l++) begin
      if (m[l]) begin
        c = c ^ {24'd0, d[8*l +: 8]};
        for (int b = 0; b < 8; b++)
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  // Word decode shared by all states.
  always_comb begin
    term_lane = 0;
    for (int i = 7; i >= 0; i--)
      if (i_mii_rx_c[i]) term_lane = i;
    lane_mask = 8'h00;
    lane_k    = 8'h00;
    hi_ok     = 1'b1;
    fd_any    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[i] = (i_mii_rx_c == 8'h00) || (i < term_lane);
      if (i == term_lane) lane_k = i_mii_rx_d[8*i +: 8];
      if (i > term_lane && !(i_mii_rx_c[i] && i_mii_rx_d[8*i +: 8] == 8'h07)) hi_ok = 1'b0;
      if (i_mii_rx_c[i] && i_mii_rx_d[8*i +: 8] == 8'hFD) fd_any = 1'b1;
    end
    start_cand = (i_mii_rx_c == 8'h01) && (i_mii_rx_d[7:0] == 8'hFB);
    pre_ok     = (i_mii_rx_d[63:8] == {8'hD5, 48'h555555555555});
    all_idle   = (i_mii_rx_c == 8'hFF) && (i_mii_rx_d == {8{8'h07}});
    crc_calc   = crc_update(crc, i_mii_rx_d, lane_mask);
    hdr_calc   = hdr;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i] && (int'(count) + i) < 14)
        hdr_calc[8*(13 - (int'(count) + i)) +: 8] = i_mii_rx_d[8*i +: 8];
    end
    n_term = count + 16'(term_lane);
  end

  always_comb begin
    state_n = state;
    crc_n   = crc;
    count_n = count;
    hdr_n   = hdr;
    pulse   = 1'b0;
    fe      = 1'b0;
    fcs_err = 1'b0;
    len_n   = 16'd0;
    if (i_rx_valid) begin
      case (state)
        IDLE: begin
          if (start_cand) begin
            if (pre_ok) begin
              state_n = DATA;
              count_n = 16'd0;
              crc_n   = 32'hFFFFFFFF;
            end else begin
              pulse   = 1'b1;
              fe      = 1'b1;
              state_n = DROP;
            end
          end
        end
        DATA: begin
          hdr_n = hdr_calc;
          if (i_mii_rx_c == 8'h00) begin
            crc_n   = crc_calc;
            count_n = count + 16'd8;
            if (count + 16'd8 > MAX_N) begin
              pulse   = 1'b1;
              fe      = 1'b1;
              state_n = DROP;
            end
          end else if (lane_k == 8'hFD && hi_ok) begin
            pulse   = 1'b1;
            fe      = (n_term < 16'd18) || (n_term > MAX_N);
            fcs_err = !fe && (crc_calc != CRC_RESIDUE);
            len_n   = (n_term < 16'd18) ? 16'd0 : n_term - 16'd18;
            state_n = IDLE;
          end else begin
            // A bad terminate word still ends the frame when lane k is FD.
            pulse   = 1'b1;
            fe      = 1'b1;
            state_n = (lane_k == 8'hFD) ? IDLE : DROP;
          end
        end
        DROP: begin
          if (fd_any || all_idle) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      crc              <= 32'hFFFFFFFF;
      count            <= 16'd0;
      hdr              <= '0;
      o_frame_done     <= 1'b0;
      o_frame_good     <= 1'b0;
      o_fcs_error      <= 1'b0;
      o_framing_error  <= 1'b0;
      o_dest_address   <= '0;
      o_src_address    <= '0;
      o_len_type       <= '0;
      o_payload_length <= '0;
      o_frame_count    <= '0;
      o_error_count    <= '0;
    end else begin
      state        <= state_n;
      crc          <= crc_n;
      count        <= count_n;
      hdr          <= hdr_n;
      o_frame_done <= pulse;
      if (pulse) begin
        o_frame_good     <= !fe && !fcs_err;
        o_fcs_error      <= fcs_err;
        o_framing_error  <= fe;
        o_dest_address   <= hdr_n[111:64];
        o_src_address    <= hdr_n[63:16];
        o_len_type       <= hdr_n[15:0];
        o_payload_length <= len_n;
        if (fe || fcs_err) begin
          if (o_error_count != 32'hFFFFFFFF) o_error_count <= o_error_count + 32'd1;
        end else begin
          if (o_frame_count != 32'hFFFFFFFF) o_frame_count <= o_frame_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mii_mac_rx_checker.sv
// tb/tb_mii_mac_rx_checker.sv - directed self-checking bench for mii_mac_rx_checker
module tb_mii_mac_rx_checker;

  localparam logic [63:0] IDLE_D = {8{8'h07}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [63:0] rx_d = IDLE_D;
  logic [7:0]  rx_c = 8'hFF;

  logic        o_frame_done, o_frame_good, o_fcs_error, o_framing_error;
  logic [47:0] o_dest_address, o_src_address;
  logic [15:0] o_len_type, o_payload_length;
  logic [31:0] o_frame_count, o_error_count;

  logic        s_done, s_good, s_fcs, s_fe;
  logic [47:0] s_dest, s_src;
  logic [15:0] s_lt, s_len;
  logic [31:0] s_fc, s_ec;

  mii_mac_rx_checker dut (
    .clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_mii_rx_d(rx_d), .i_mii_rx_c(rx_c),
    .o_frame_done(o_frame_done), .o_frame_good(o_frame_good), .o_fcs_error(o_fcs_error),
    .o_framing_error(o_framing_error), .o_dest_address(o_dest_address),
    .o_src_address(o_src_address), .o_len_type(o_len_type),
    .o_payload_length(o_payload_length), .o_frame_count(o_frame_count),
    .o_error_count(o_error_count)
  );

  mii_mac_rx_checker #(.PAYLOAD_MAX_SIZE(64)) dut_s (
    .clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_mii_rx_d(rx_d), .i_mii_rx_c(rx_c),
    .o_frame_done(s_done), .o_frame_good(s_good), .o_fcs_error(s_fcs),
    .o_framing_error(s_fe), .o_dest_address(s_dest), .o_src_address(s_src),
    .o_len_type(s_lt), .o_payload_length(s_len), .o_frame_count(s_fc), .o_error_count(s_ec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int s_pulses = 0;
  int pulse_word = -1;
  int s_pulse_word = -1;
  int word_idx = -1;
  int exp_fc = 0;
  int exp_ec = 0;
  logic [7:0] fb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All clocking goes through here so pulse bookkeeping never races the driver.
  task automatic tick();
    @(negedge clk);
    if (o_frame_done) begin
      pulses++;
      pulse_word = word_idx;
    end
    if (s_done) begin
      s_pulses++;
      s_pulse_word = word_idx;
    end
  endtask

  function automatic logic [31:0] crc_model(input int nbytes);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nbytes; i++) begin
      c = c ^ {24'd0, fb[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_frame(input int plen, input logic [7:0] fill);
    logic [31:0] fcs;
    logic [7:0] hdr_bytes [14];
    hdr_bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h08, 8'h00};
    fb = {};
    for (int i = 0; i < 14; i++) fb.push_back(hdr_bytes[i]);
    for (int i = 0; i < plen; i++) fb.push_back(fill);
    fcs = ~crc_model(fb.size());
    fb.push_back(fcs[7:0]);
    fb.push_back(fcs[15:8]);
    fb.push_back(fcs[23:16]);
    fb.push_back(fcs[31:24]);
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] c, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        rx_valid = 1'b0;
        rx_d = {$urandom, $urandom};
        rx_c = 8'($urandom);
      end
    end
    tick();
    word_idx++;
    rx_valid = 1'b1;
    rx_d = d;
    rx_c = c;
  endtask

  task automatic send_frame(input bit gaps, input logic [7:0] sfd, output logic done_after);
    int nfull, r;
    logic [63:0] d;
    logic [7:0] c;
    word_idx = -1;
    send_word({sfd, 48'h555555555555, 8'hFB}, 8'h01, gaps);
    nfull = fb.size() / 8;
    r = fb.size() % 8;
    for (int w = 0; w < nfull; w++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = fb[8*w + i];
      send_word(d, 8'h00, gaps);
    end
    d = IDLE_D;
    for (int i = 0; i < r; i++) d[8*i +: 8] = fb[8*nfull + i];
    d[8*r +: 8] = 8'hFD;
    c = 8'hFF;
    c = c << r;
    send_word(d, c, gaps);
    tick();
    done_after = o_frame_done;
    rx_valid = 1'b1;
    rx_d = IDLE_D;
    rx_c = 8'hFF;
    repeat (3) tick();
  endtask

  task automatic run_good(input bit gaps, input int plen, input string tag);
    int p0;
    logic dn;
    build_frame(plen, 8'h55);
    p0 = pulses;
    send_frame(gaps, 8'hD5, dn);
    exp_fc++;
    check_eq({tag, " done"}, dn, 1'b1);
    check_eq({tag, " pulses"}, pulses - p0, 1);
    check_eq({tag, " good"}, o_frame_good, 1'b1);
    check_eq({tag, " len"}, o_payload_length, 16'(plen));
    check_eq({tag, " fcount"}, o_frame_count, exp_fc);
  endtask

  initial begin
    logic dn;
    int p0, s0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst done", o_frame_done, 1'b0);
    check_eq("rst fcount", o_frame_count, 0);
    check_eq("rst ecount", o_error_count, 0);
    check_eq("rst dest", o_dest_address, 48'h0);
    check_eq("rst len", o_payload_length, 16'h0);

    // Good 64-byte frame: terminate in lane 0 of word 9.
    run_good(1'b0, 46, "g64");
    check_eq("g64 done width", o_frame_done, 1'b0);
    check_eq("g64 pulse word", pulse_word, 9);
    check_eq("g64 dest", o_dest_address, 48'h001122334455);
    check_eq("g64 src", o_src_address, 48'hAABBCCDDEEFF);
    check_eq("g64 type", o_len_type, 16'h0800);
    check_eq("g64 fcs", o_fcs_error, 1'b0);
    check_eq("g64 fe", o_framing_error, 1'b0);
    check_eq("g64 ecount", o_error_count, 0);

    // Flipped FCS bit.
    build_frame(46, 8'h55);
    fb[fb.size() - 1] = fb[fb.size() - 1] ^ 8'h01;
    p0 = pulses;
    send_frame(1'b0, 8'hD5, dn);
    exp_ec++;
    check_eq("fcs done", dn, 1'b1);
    check_eq("fcs pulses", pulses - p0, 1);
    check_eq("fcs good", o_frame_good, 1'b0);
    check_eq("fcs fcs", o_fcs_error, 1'b1);
    check_eq("fcs fe", o_framing_error, 1'b0);
    check_eq("fcs ecount", o_error_count, exp_ec);
    check_eq("fcs fcount", o_frame_count, exp_fc);

    // Terminate in every lane, without and with valid gaps.
    for (int g = 0; g < 2; g++)
      for (int pl = 46; pl <= 53; pl++)
        run_good(g[0], pl, $sformatf("lane g%0d n%0d", g, pl + 18));

    // Bad SFD aborts on the start word; the rest of the frame is dropped.
    build_frame(46, 8'h55);
    p0 = pulses;
    send_frame(1'b0, 8'hD7, dn);
    exp_ec++;
    check_eq("sfd pulses", pulses - p0, 1);
    check_eq("sfd pulse word", pulse_word, 0);
    check_eq("sfd fe", o_framing_error, 1'b1);
    check_eq("sfd good", o_frame_good, 1'b0);
    check_eq("sfd ecount", o_error_count, exp_ec);
    run_good(1'b0, 46, "after sfd");

    // Oversize for the 64-byte-payload instance: abort when count passes 82 (data word 11).
    build_frame(100, 8'hA5);
    s0 = s_pulses;
    s_pulse_word = -1;
    send_frame(1'b0, 8'hD5, dn);
    exp_fc++;
    check_eq("big main good", o_frame_good, 1'b1);
    check_eq("big main len", o_payload_length, 16'd100);
    check_eq("big s pulses", s_pulses - s0, 1);
    check_eq("big s pulse word", s_pulse_word, 11);
    check_eq("big s fe", s_fe, 1'b1);
    check_eq("big s good", s_good, 1'b0);
    s0 = s_pulses;
    run_good(1'b0, 46, "after big");
    check_eq("after big s pulses", s_pulses - s0, 1);
    check_eq("after big s good", s_good, 1'b1);

    // Reset in the middle of a frame.
    build_frame(46, 8'h55);
    word_idx = -1;
    send_word({8'hD5, 48'h555555555555, 8'hFB}, 8'h01, 1'b0);
    for (int w = 0; w < 3; w++) begin
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[8*i +: 8] = fb[8*w + i];
      send_word(d, 8'h00, 1'b0);
    end
    tick();
    p0 = pulses;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_d = IDLE_D;
    rx_c = 8'hFF;
    #1;
    check_eq("mid rst fcount", o_frame_count, 0);
    check_eq("mid rst ecount", o_error_count, 0);
    check_eq("mid rst good", o_frame_good, 1'b0);
    check_eq("mid rst len", o_payload_length, 16'h0);
    check_eq("mid rst dest", o_dest_address, 48'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_eq("mid rst no pulse", pulses - p0, 0);
    exp_fc = 0;
    exp_ec = 0;
    run_good(1'b0, 46, "after rst");
    check_eq("after rst ecount", o_error_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mii_mac_rx_checker.md
Name: mii_mac_rx_checker

Overview:
- Receive-side counterpart of the MAC/MII frame generator.
- Consumes the 64-bit, 8-lane MII data/control stream and delineates frames on Start/Terminate control characters.
- Checks preamble/SFD and the Ethernet FCS, extracts the header fields, and reports per-frame status plus running counters.
- Sits at the loopback/sink end of the verification datapath; it is the scoreboard-facing checker for the generator.

Parameters:
- PAYLOAD_MAX_SIZE, 1500, maximum payload bytes; longer frames are framing errors.
- CRC_RESIDUE, 32'hDEBB20E3, expected CRC register value after all frame bytes including FCS.

Ports:
- clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_rx_valid  in  1  the current word is valid; words with i_rx_valid low are ignored and all state holds
- i_mii_rx_d  in  64  MII data; lane i = bits [8i+7:8i]; lane 0 is first on the wire
- i_mii_rx_c  in  8  MII control; bit i = 1 means lane i is a control character
- o_frame_done  out  1  one-cycle pulse when a frame ends or is aborted
- o_frame_good  out  1  valid with o_frame_done: no FCS error and no framing error
- o_fcs_error  out  1  valid with o_frame_done
- o_framing_error  out  1  valid with o_frame_done
- o_dest_address  out  48  first 6 frame bytes; first byte maps to [47:40]
- o_src_address  out  48  frame bytes 6..11, same ordering
- o_len_type  out  16  frame bytes 12..13; byte 12 maps to [15:8]
- o_payload_length  out  16  N-18, where N = bytes between SFD and Terminate
- o_frame_count  out  32  completed good frames, saturating
- o_error_count  out  32  bad or aborted frames, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, CRC 32'hFFFFFFFF. Reset mid-frame discards the frame with no done pulse.
- CRC: reflected Ethernet CRC-32 (poly 0x04C11DB7 reflected, init all-ones, no final XOR), computed combinationally over the valid data lanes of each word. Last word uses a lane mask.
- States: IDLE, DATA, DROP. All transitions evaluate only on words with i_rx_valid=1.
- IDLE:
  - Start word: ctrl==8'h01, lane0==FB, lanes1-6==55, lane7==D5. Go to DATA; byte count=0; CRC=all-ones.
  - Word with ctrl==8'h01 and lane0==FB but a bad preamble/SFD: done pulse with framing_error=1; go to DROP.
  - All other words (idle, error characters): ignored.
- DATA, ctrl==0:
  - 8 bytes go through CRC; count+=8; header bytes are captured by byte index.
  - If count exceeds PAYLOAD_MAX_SIZE+18: framing error pulse, go to DROP.
- DATA, ctrl!=0:
  - k = lowest set ctrl bit. Lanes <k are data; lane k must be FD.
  - All bits above k must be set and those lanes must be 07.
  - Pass: N = count+k. Finalize; go to IDLE.
  - Any violation (including FB or FE anywhere): framing error pulse, go to DROP. If lane k is FD, go to IDLE instead.
- Finalize:
  - framing_error = (N<18) or (N>PAYLOAD_MAX_SIZE+18).
  - fcs_error = !framing_error and CRC≠CRC_RESIDUE.
  - good = !fcs_error && !framing_error. Increment the matching counter.
- DROP: leave for IDLE on a word containing FD in any control lane, or an all-idle word (ctrl FF, all lanes 07). No further pulse. A Start in the same word is not accepted.
- Latency: the Terminate/abort word sampled at edge n sets o_frame_done for exactly the cycle after edge n. Status, header and length outputs update at the same edge and hold until the next done.
- Header fields of frames with N<14 hold stale bytes; length is reported as 0 when N<18.
- A Start word arriving the cycle after the done pulse is accepted. Counters saturate at 32'hFFFFFFFF.

Test Plan:
- Good 64-byte frame: dest 001122334455, src AABBCCDDEEFF, type 0800, 46×0x55, correct FCS, i_rx_valid continuous -> one done pulse, good=1, payload_length=46, fields match, frame_count=1, error_count=0.
- Same frame with one FCS bit flipped -> good=0, fcs_error=1, framing_error=0, error_count=1.
- Frames N=64..71 so Terminate lands in lanes 0..7 -> payload_length 46..53, all good. Repeat with random i_rx_valid gaps -> identical results.
- SFD lane7=D7 -> immediate done pulse, framing_error=1. Next correct frame -> good=1.
- PAYLOAD_MAX_SIZE=64 with a 100-byte payload -> framing_error pulse on the word where count exceeds 82, no second pulse at FD. Following frame good.
- i_rst pulsed mid-frame -> all outputs 0, no done pulse. Next frame good, frame_count=1.
